// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, optional signed operation,
// start/busy/done handshake with held results and divide-by-zero / overflow flags.
module seq_divider #(
  parameter int N     = 16,
  parameter int CNT_W = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         i_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero,
  output logic         ovf
);

  // state  | meaning
  // IDLE   | waiting for start
  // CALC   | one shift/subtract iteration per cycle, N cycles
  // FIX    | sign correction, load result outputs
  // DONE   | done pulse for one cycle; start accepted here too
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_dvd_shift;
  logic [N-1:0]     r_dvs_mag;
  logic [N-1:0]     r_dvd_raw;
  logic [N-1:0]     r_rem;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz;
  logic             r_ovf;

  logic             w_accept;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [N-1:0]     w_dvd_mag;
  logic [N-1:0]     w_dvs_mag;
  logic [N:0]       w_shift;
  logic [N:0]       w_diff;
  logic [N-1:0]     w_q_fix;
  logic [N-1:0]     w_r_fix;

  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_dvd_neg = i_signed && dividend[N-1];
  assign w_dvs_neg = i_signed && divisor[N-1];
  // Negating the most-negative value yields itself, which is the correct unsigned magnitude.
  assign w_dvd_mag = w_dvd_neg ? (-dividend) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (-divisor) : divisor;

  // Remainder stays below the divisor, so N stored bits plus the shifted-in bit suffice.
  assign w_shift = {r_rem, r_dvd_shift[N-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs_mag};

  assign w_q_fix = r_q_neg ? (-r_dvd_shift) : r_dvd_shift;
  assign w_r_fix = r_r_neg ? (-r_rem) : r_rem;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) w_next = (divisor == '0) ? S_FIX : S_CALC;
        else       w_next = S_IDLE;
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == '0) w_next = S_FIX;
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_dvd_shift <= '0;
      r_dvs_mag   <= '0;
      r_dvd_raw   <= '0;
      r_rem       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_zero    <= 1'b0;
      ovf         <= 1'b0;
    end else if (w_accept) begin
      r_cnt       <= CNT_W'(N-1);
      r_dvd_shift <= w_dvd_mag;
      r_dvs_mag   <= w_dvs_mag;
      r_dvd_raw   <= dividend;
      r_rem       <= '0;
      r_q_neg     <= w_dvd_neg ^ w_dvs_neg;
      r_r_neg     <= w_dvd_neg;
      r_dz        <= (divisor == '0);
      r_ovf       <= i_signed && (dividend == MOST_NEG) && (divisor == '1);
      quotient    <= '0;
      remainder   <= '0;
      div_zero    <= 1'b0;
      ovf         <= 1'b0;
    end else if (r_state == S_CALC) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      if (!w_diff[N]) begin
        r_rem       <= w_diff[N-1:0];
        r_dvd_shift <= {r_dvd_shift[N-2:0], 1'b1};
      end else begin
        r_rem       <= w_shift[N-1:0];
        r_dvd_shift <= {r_dvd_shift[N-2:0], 1'b0};
      end
    end else if (r_state == S_FIX) begin
      if (r_dz) begin
        quotient  <= '1;
        remainder <= r_dvd_raw;
        div_zero  <= 1'b1;
        ovf       <= 1'b0;
      end else begin
        quotient  <= w_q_fix;
        remainder <= w_r_fix;
        div_zero  <= 1'b0;
        ovf       <= r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued when an operation is
// started and compared when done is seen; latency, handshake and reset abort are checked inline.
module tb_seq_divider;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         i_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;
  logic         ovf;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ov;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .i_signed(i_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t mk(input logic [N-1:0] q, input logic [N-1:0] r,
                              input logic dz, input logic ov);
    res_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov;
    return e;
  endfunction

  // Independent reference: language division truncates toward zero, % takes the dividend sign.
  function automatic res_t model(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [N-1:0] sa;
    logic signed [N-1:0] sbv;
    res_t e;
    sa = a;
    sbv = b;
    if (b == '0)                                  e = mk('1, a, 1'b1, 1'b0);
    else if (sgn && a == 16'h8000 && b == 16'hFFFF) e = mk(16'h8000, '0, 1'b0, 1'b1);
    else if (sgn)                                 e = mk(sa / sbv, sa % sbv, 1'b0, 1'b0);
    else                                          e = mk(a / b, a % b, 1'b0, 1'b0);
    return e;
  endfunction

  function automatic res_t dut_res();
    return mk(quotient, remainder, div_zero, ovf);
  endfunction

  function automatic res_t sb_pop();
    res_t e;
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic drive(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit push, input res_t e);
    i_signed = sgn;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back(e);
  endtask

  // Counts edges from the one that samples start until done is seen, bounded.
  task automatic wait_done(output int edges, output int busy_cyc);
    bit got;
    edges = 0; busy_cyc = 0; got = 0;
    while (!got && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (done) got = 1;
      else if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; i_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (quotient !== '0)   begin n_fail++; $display("FAIL reset_quotient: got %h expected 0", quotient); end
    n_checks++; if (remainder !== '0)  begin n_fail++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
    n_checks++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int edges, bc;
    res_t e, g;
    drive(1'b0, 16'd100, 16'd7, 1, mk(16'd14, 16'd2, 1'b0, 1'b0));
    wait_done(edges, bc);
    n_checks++; if (edges !== 18) begin n_fail++; $display("FAIL unsigned_latency: got %0d edges expected 18", edges); end
    n_checks++; if (bc !== 17)    begin n_fail++; $display("FAIL unsigned_busy: got %0d busy cycles expected 17", bc); end
    e = sb_pop(); g = dut_res();
    n_checks++; if (g !== e) begin n_fail++; $display("FAIL unsigned_result: got %h expected %h", g, e); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    g = dut_res();
    n_checks++; if (g !== mk(16'd14, 16'd2, 1'b0, 1'b0)) begin n_fail++; $display("FAIL result_held: got %h expected %h", g, mk(16'd14, 16'd2, 1'b0, 1'b0)); end
  endtask

  task automatic test_signed();
    int edges, bc;
    res_t e, g;
    logic [N-1:0] a_tab [3] = '{16'hFF9C, 16'd100, 16'hFF9C};
    logic [N-1:0] b_tab [3] = '{16'd7, 16'hFFF9, 16'hFFF9};
    res_t e_tab [3] = '{mk(16'hFFF2, 16'hFFFE, 1'b0, 1'b0), mk(16'hFFF2, 16'h0002, 1'b0, 1'b0),
                        mk(16'h000E, 16'hFFFE, 1'b0, 1'b0)};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, a_tab[i], b_tab[i], 1, e_tab[i]);
      wait_done(edges, bc);
      n_checks++; if (edges !== 18) begin n_fail++; $display("FAIL signed_latency[%0d]: got %0d expected 18", i, edges); end
      e = sb_pop(); g = dut_res();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL signed_result[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_overflow();
    int edges, bc;
    res_t e, g;
    drive(1'b1, 16'h8000, 16'hFFFF, 1, mk(16'h8000, 16'h0000, 1'b0, 1'b1));
    wait_done(edges, bc);
    n_checks++; if (edges !== 18) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 18", edges); end
    e = sb_pop(); g = dut_res();
    n_checks++; if (g !== e) begin n_fail++; $display("FAIL ovf_signed: got %h expected %h", g, e); end
    drive(1'b0, 16'h8000, 16'hFFFF, 1, mk(16'h0000, 16'h8000, 1'b0, 1'b0));
    wait_done(edges, bc);
    e = sb_pop(); g = dut_res();
    n_checks++; if (g !== e) begin n_fail++; $display("FAIL ovf_unsigned: got %h expected %h", g, e); end
  endtask

  task automatic test_div_zero();
    int edges, bc;
    res_t e, g;
    drive(1'b0, 16'd1234, 16'd0, 1, mk(16'hFFFF, 16'd1234, 1'b1, 1'b0));
    wait_done(edges, bc);
    n_checks++; if (edges !== 2) begin n_fail++; $display("FAIL dz_latency: got %0d expected 2", edges); end
    n_checks++; if (bc !== 1)    begin n_fail++; $display("FAIL dz_busy: got %0d expected 1", bc); end
    e = sb_pop(); g = dut_res();
    n_checks++; if (g !== e) begin n_fail++; $display("FAIL dz_unsigned: got %h expected %h", g, e); end
    drive(1'b1, 16'hFFFB, 16'd0, 1, mk(16'hFFFF, 16'hFFFB, 1'b1, 1'b0));
    wait_done(edges, bc);
    e = sb_pop(); g = dut_res();
    n_checks++; if (g !== e) begin n_fail++; $display("FAIL dz_signed: got %h expected %h", g, e); end
  endtask

  task automatic test_ignore_start();
    int edges;
    bit got;
    res_t e, g;
    drive(1'b0, 16'd100, 16'd7, 1, mk(16'd14, 16'd2, 1'b0, 1'b0));
    edges = 0; got = 0;
    while (!got && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (edges == 5) drive(1'b1, 16'd50, 16'd5, 0, '0);
      if (done) got = 1;
    end
    n_checks++; if (edges !== 18) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 18", edges); end
    e = sb_pop(); g = dut_res();
    n_checks++; if (g !== e) begin n_fail++; $display("FAIL ignore_result: got %h expected %h", g, e); end
  endtask

  task automatic test_back_to_back();
    int edges, bc;
    res_t e, g;
    drive(1'b0, 16'd9, 16'd2, 1, mk(16'd4, 16'd1, 1'b0, 1'b0));
    wait_done(edges, bc);
    e = sb_pop(); g = dut_res();
    n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", g, e); end
    drive(1'b0, 16'd65535, 16'd255, 1, mk(16'd257, 16'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || quotient !== '0 || remainder !== '0)
      begin n_fail++; $display("FAIL b2b_accept: got busy=%b q=%h r=%h expected busy=1 q=0 r=0", busy, quotient, remainder); end
    wait_done(edges, bc);
    n_checks++; if (edges + 1 !== 18) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 18", edges + 1); end
    e = sb_pop(); g = dut_res();
    n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", g, e); end
  endtask

  task automatic test_reset_abort();
    int edges, bc, pulses;
    res_t e, g;
    drive(1'b0, 16'd100, 16'd7, 0, '0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    g = dut_res();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || g !== '0)
      begin n_fail++; $display("FAIL abort_state: got busy=%b done=%b res=%h expected all 0", busy, done, g); end
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
    drive(1'b0, 16'd9, 16'd3, 1, mk(16'd3, 16'd0, 1'b0, 1'b0));
    wait_done(edges, bc);
    e = sb_pop(); g = dut_res();
    n_checks++; if (g !== e) begin n_fail++; $display("FAIL abort_fresh: got %h expected %h", g, e); end
  endtask

  task automatic test_random();
    int edges, bc;
    res_t e, g;
    logic [N-1:0] a, b;
    logic sg;
    for (int i = 0; i < 24; i++) begin
      a  = N'($urandom);
      b  = (i % 6 == 5) ? '0 : N'($urandom_range(0, (i % 2) ? 65535 : 300));
      sg = 1'($urandom_range(0, 1));
      drive(sg, a, b, 1, model(sg, a, b));
      wait_done(edges, bc);
      e = sb_pop(); g = dut_res();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL random[%0d] s=%b %h/%h: got %h expected %h", i, sg, a, b, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
